// File: rtl/relu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : relu_pkg
// Brief   : Activation mode encoding and lane popcount helper.
// Revision: 1.0 - initial release
// ============================================================================
package relu_pkg;

    typedef enum logic [1:0] {
        MODE_RELU   = 2'b00,
        MODE_LEAKY  = 2'b01,
        MODE_CLAMP  = 2'b10,
        MODE_BYPASS = 2'b11
    } relu_mode_e;

    localparam int MAX_LANES = 32;
    localparam int PC_W      = 6;

    function automatic logic [PC_W-1:0] lane_popcount(input logic [MAX_LANES-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + {{(PC_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/relu_vector_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : relu_vector_pipe_if
// Brief   : Input/output stream handshake and statistics bus.
// Revision: 1.0 - initial release
// ============================================================================
interface relu_vector_pipe_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) ();
    logic                       in_valid;
    logic                       in_ready;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic [1:0]                 in_mode;
    logic                       out_valid;
    logic                       out_ready;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic                       clear_stats;
    logic [CNT_W-1:0]           neg_count;

    modport master (
        output in_valid, in_data, in_mode, out_ready, clear_stats,
        input  in_ready, out_valid, out_data, neg_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready, clear_stats,
        output in_ready, out_valid, out_data, neg_count
    );
endinterface
`default_nettype wire

// File: rtl/relu_lane.sv
`default_nettype none
// ============================================================================
// Module  : relu_lane
// Brief   : Combinational single-lane activation with negative flag.
// Revision: 1.0 - initial release
// ============================================================================
module relu_lane
    import relu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_MAX  = 6
) (
    input  logic signed [DATA_W-1:0] x_i,
    input  relu_mode_e               mode_i,
    output logic signed [DATA_W-1:0] y_o,
    output logic                     is_neg_o
);
    localparam logic signed [DATA_W-1:0] c_clamp_max = DATA_W'(CLAMP_MAX);

    assign is_neg_o = x_i[DATA_W-1];

    always_comb begin
        y_o = x_i;
        unique case (mode_i)
            MODE_RELU: begin
                if (is_neg_o) y_o = '0;
            end
            MODE_LEAKY: begin
                // Arithmetic shift floors toward -inf, so -1 stays -1.
                if (is_neg_o) y_o = x_i >>> LEAK_SHIFT;
            end
            MODE_CLAMP: begin
                if (is_neg_o)                 y_o = '0;
                else if (x_i > c_clamp_max)   y_o = c_clamp_max;
            end
            default: y_o = x_i;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/relu_vector_pipe.sv
`default_nettype none
// ============================================================================
// Module  : relu_vector_pipe
// Brief   : CHANNELS-lane activation behind a 2-stage valid/ready pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module relu_vector_pipe
    import relu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CHANNELS   = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int CLAMP_MAX  = 6,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    relu_vector_pipe_if.slave    bus
);
    localparam int VEC_W = CHANNELS * DATA_W;
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic                 s1_valid_q;
    logic [VEC_W-1:0]     s1_data_q;
    relu_mode_e           s1_mode_q;
    logic                 s2_valid_q;
    logic [VEC_W-1:0]     s2_data_q;
    logic [CNT_W-1:0]     neg_count_q;
    logic [CNT_W-1:0]     neg_count_d;

    logic                 w_adv1;
    logic                 w_adv2;
    logic                 w_move;
    logic [VEC_W-1:0]     w_act;
    logic [CHANNELS-1:0]  w_is_neg;
    logic [MAX_LANES-1:0] w_neg_vec;
    logic [PC_W-1:0]      w_neg_lanes;
    logic [SUM_W-1:0]     w_sum;
    logic [SUM_W-1:0]     w_cnt_max;

    assign w_adv2 = !s2_valid_q || bus.out_ready;
    assign w_adv1 = !s1_valid_q || w_adv2;
    assign w_move = s1_valid_q && w_adv2;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        relu_lane #(
            .DATA_W     (DATA_W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .CLAMP_MAX  (CLAMP_MAX)
        ) u_lane (
            .x_i      (s1_data_q[i*DATA_W +: DATA_W]),
            .mode_i   (s1_mode_q),
            .y_o      (w_act[i*DATA_W +: DATA_W]),
            .is_neg_o (w_is_neg[i])
        );
    end

    // Clear wins over a coincident increment; the sum is one bit wider so saturation is exact.
    always_comb begin
        w_neg_vec                 = '0;
        w_neg_vec[CHANNELS-1:0]   = w_is_neg;
        w_neg_lanes               = lane_popcount(w_neg_vec);
        w_cnt_max                 = SUM_W'({CNT_W{1'b1}});
        w_sum                     = SUM_W'(neg_count_q) + SUM_W'(w_neg_lanes);
        neg_count_d               = neg_count_q;
        if (bus.clear_stats) begin
            neg_count_d = '0;
        end else if (w_move) begin
            neg_count_d = (w_sum > w_cnt_max) ? w_cnt_max[CNT_W-1:0] : w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= MODE_RELU;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            neg_count_q <= '0;
        end else begin
            if (w_adv1) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_data_q <= bus.in_data;
                    s1_mode_q <= relu_mode_e'(bus.in_mode);
                end
            end
            if (w_adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= w_act;
            end
            neg_count_q <= neg_count_d;
        end
    end

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_data  = s2_data_q;
    assign bus.neg_count = neg_count_q;
endmodule
`default_nettype wire

// File: tb/tb_relu_vector_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_relu_vector_pipe
// Brief   : Scoreboard bench for relu_vector_pipe (16-bit and 4-bit counters).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_relu_vector_pipe;
    import relu_pkg::*;

    localparam int DATA_W = 8;
    localparam int CH     = 4;
    localparam int VEC_W  = DATA_W * CH;

    typedef struct {
        logic [VEC_W-1:0] data;
        int               cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    relu_vector_pipe_if #(.DATA_W(DATA_W), .CHANNELS(CH), .CNT_W(16)) bus  ();
    relu_vector_pipe_if #(.DATA_W(DATA_W), .CHANNELS(CH), .CNT_W(4))  bus4 ();

    assign bus4.in_valid    = bus.in_valid;
    assign bus4.in_data     = bus.in_data;
    assign bus4.in_mode     = bus.in_mode;
    assign bus4.out_ready   = bus.out_ready;
    assign bus4.clear_stats = bus.clear_stats;

    relu_vector_pipe #(.DATA_W(DATA_W), .CHANNELS(CH), .LEAK_SHIFT(3), .CLAMP_MAX(6), .CNT_W(16))
        dut (.clk(clk), .reset(reset), .bus(bus));
    relu_vector_pipe #(.DATA_W(DATA_W), .CHANNELS(CH), .LEAK_SHIFT(3), .CLAMP_MAX(6), .CNT_W(4))
        dut4 (.clk(clk), .reset(reset), .bus(bus4));

    exp_t             sb_q[$];
    int               n_tests   = 0;
    int               n_fail    = 0;
    int               exp16     = 0;
    int               exp4      = 0;
    bit               check_lat = 1'b0;
    bit               saw_stall = 1'b0;
    bit               holding   = 1'b0;
    logic [VEC_W-1:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [VEC_W-1:0] pack(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic int count_neg(input logic [VEC_W-1:0] v);
        int n = 0;
        for (int i = 0; i < CH; i++) if (v[i*DATA_W + DATA_W - 1]) n++;
        return n;
    endfunction

    // Monitor: pops on every output transfer, checks hold-while-stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            holding = 1'b0;
        end else begin
            if (holding) begin
                chk("stall_hold_valid", bus.out_valid, 1);
                chk("stall_hold_data", bus.out_data, held);
            end
            holding = 1'b0;
            if (!bus.in_ready) saw_stall = 1'b1;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_beat_queue_size", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("out_data", bus.out_data, e.data);
                        if (check_lat) chk("latency", cyc - e.cyc, 2);
                    end
                end else begin
                    holding = 1'b1;
                    held    = bus.out_data;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] mode, input logic [VEC_W-1:0] din, input logic [VEC_W-1:0] dexp);
        exp_t e;
        int   waited = 0;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_data  = din;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 50) begin
                chk("in_ready_timeout", bus.in_ready, 1);
                break;
            end
        end
        e.data = dexp;
        e.cyc  = cyc;
        sb_q.push_back(e);
        n     = count_neg(din);
        exp16 = exp16 + n;
        exp4  = (exp4 + n > 15) ? 15 : exp4 + n;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 60) begin
            @(posedge clk);
            w++;
        end
        chk("drain_queue_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_neg_count16"}, bus.neg_count, exp16);
        chk({tag, "_neg_count4"}, bus4.neg_count, exp4);
    endtask

    logic [1:0]       bp_mode [6];
    logic [VEC_W-1:0] bp_in   [6];
    logic [VEC_W-1:0] bp_exp  [6];

    initial begin
        bp_mode[0] = MODE_RELU;   bp_in[0] = pack(1, 2, 3, 4);          bp_exp[0] = pack(1, 2, 3, 4);
        bp_mode[1] = MODE_LEAKY;  bp_in[1] = pack(-16, 16, -8, -9);     bp_exp[1] = pack(-2, 16, -1, -2);
        bp_mode[2] = MODE_CLAMP;  bp_in[2] = pack(100, -100, 3, 6);     bp_exp[2] = pack(6, 0, 3, 6);
        bp_mode[3] = MODE_BYPASS; bp_in[3] = pack(-1, -2, -3, -4);      bp_exp[3] = pack(-1, -2, -3, -4);
        bp_mode[4] = MODE_RELU;   bp_in[4] = pack(-7, 8, -9, 10);       bp_exp[4] = pack(0, 8, 0, 10);
        bp_mode[5] = MODE_LEAKY;  bp_in[5] = pack(-127, -64, 63, -2);   bp_exp[5] = pack(-16, -8, 63, -1);

        // Reset held with a valid beat presented
        bus.in_valid    = 1'b1;
        bus.in_data     = pack(1, -2, 3, -4);
        bus.in_mode     = MODE_RELU;
        bus.out_ready   = 1'b1;
        bus.clear_stats = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk_cnt("reset");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", bus.in_ready, 1);
        chk("post_reset_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // Single RELU beat, then per-mode beats back to back
        check_lat = 1'b1;
        send(MODE_RELU, pack(12, -3, 5, -10), pack(12, 0, 5, 0));
        drain();
        chk_cnt("relu");
        send(MODE_LEAKY,  pack(-10, -1, -128, 7), pack(-2, -1, -16, 7));
        send(MODE_CLAMP,  pack(12, 6, -3, 0),     pack(6, 6, 0, 0));
        send(MODE_BYPASS, pack(-5, 127, -128, 0), pack(-5, 127, -128, 0));
        send(MODE_RELU,   pack(-128, 127, 0, -1), pack(0, 127, 0, 0));
        send(MODE_CLAMP,  pack(7, -128, 5, 127),  pack(6, 0, 5, 6));
        drain();
        chk_cnt("modes");
        check_lat = 1'b0;

        // Backpressure mid-stream
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(bp_mode[i], bp_in[i], bp_exp[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_dropped", saw_stall, 1);
        chk_cnt("bp");

        // Counter saturation and clear priority
        bus.clear_stats = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_stats = 1'b0;
        exp16 = 0;
        exp4  = 0;
        chk_cnt("clear");
        for (int i = 0; i < 5; i++) send(MODE_BYPASS, pack(-1, -1, -1, -1), pack(-1, -1, -1, -1));
        drain();
        chk_cnt("saturate");
        send(MODE_BYPASS, pack(-3, -3, -3, -3), pack(-3, -3, -3, -3));
        bus.clear_stats = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_stats = 1'b0;
        exp16 = 0;
        exp4  = 0;
        drain();
        chk_cnt("clear_coincident");

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send(MODE_RELU, pack(1, 1, 1, 1), pack(1, 1, 1, 1));
        send(MODE_RELU, pack(2, 2, 2, 2), pack(2, 2, 2, 2));
        @(negedge clk);
        chk("full_in_ready_low", bus.in_ready, 0);
        chk("full_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        exp16 = 0;
        exp4  = 0;
        @(negedge clk);
        chk("midreset_out_valid", bus.out_valid, 0);
        chk_cnt("midreset");
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        check_lat     = 1'b1;
        send(MODE_LEAKY, pack(-24, 24, -25, 0), pack(-3, 24, -4, 0));
        drain();
        check_lat = 1'b0;
        chk_cnt("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
